// File: rtl/disp_pkg.sv
// Shared message codes, scheduler states and magnitude limit for the display scheduler.
package disp_pkg;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_OP  = 2'b01;
    localparam logic [1:0] MSG_VAL = 2'b10;
    localparam logic [1:0] MSG_ERR = 2'b11;

    localparam logic [9:0] MAG_MAX = 10'd255;

    typedef enum logic [1:0] {
        ST_NUM    = 2'd0,
        ST_PROMPT = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

endpackage

// File: rtl/disp_hold_timer.sv
// ERR hold timer: counts enabled cycles from a clear, flags done on count ERR_HOLD-1.
// Latency: done is combinational from the registered count; clear wins over enable.
// Backpressure: none, free-running while enabled.
module disp_hold_timer #(
    parameter int ERR_HOLD = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ERR_HOLD - 1);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    assign done = en & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/disp_msg_sched.sv
// Display scheduler: arbitrates error/result/prompt events into decoder writes, sign/magnitude.
// Latency: event at edge N drives registered outputs and a one-cycle write strobe at edge N+1.
// Backpressure: res_ready drops during ERR hold or a same-cycle err_req; losing events are dropped.
module disp_msg_sched
    import disp_pkg::*;
#(
    parameter int ERR_HOLD = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [9:0] res_value,
    input  logic [1:0] res_dot,
    input  logic       err_req,
    input  logic       prompt_req,
    input  logic       prompt_sel,
    output logic       busy,
    output logic [1:0] disp_msg,
    output logic       disp_wr,
    output logic       disp_sel,
    output logic [7:0] disp_bin,
    output logic       disp_sgn,
    output logic [1:0] disp_dot
);

    state_t     state, state_n;
    logic [1:0] msg_n;
    logic [7:0] bin_n;
    logic       sgn_n;
    logic [1:0] dot_n;
    logic       wr_n;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_done;
    logic [9:0] mag;
    logic       ovf;

    // Ten-bit negation maps -512 onto 512, which the overflow check then rejects.
    assign mag       = res_value[9] ? (~res_value + 10'd1) : res_value;
    assign ovf       = mag > MAG_MAX;
    assign res_ready = (state != ST_ERR) & ~err_req;
    assign tmr_en    = (state == ST_ERR);
    assign busy      = tmr_en;
    assign disp_sel  = disp_wr;

    disp_hold_timer #(
        .ERR_HOLD (ERR_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clr),
        .en    (tmr_en),
        .done  (tmr_done)
    );

    always_comb begin
        state_n = state;
        msg_n   = disp_msg;
        bin_n   = disp_bin;
        sgn_n   = disp_sgn;
        dot_n   = disp_dot;
        wr_n    = 1'b0;
        tmr_clr = 1'b0;
        if (err_req) begin
            state_n = ST_ERR;
            msg_n   = MSG_ERR;
            wr_n    = 1'b1;
            tmr_clr = 1'b1;
        end else if (state == ST_ERR) begin
            if (tmr_done) begin
                state_n = ST_NUM;
                msg_n   = MSG_NUM;
                bin_n   = '0;
                sgn_n   = 1'b0;
                dot_n   = '0;
                wr_n    = 1'b1;
                tmr_clr = 1'b1;
            end
        end else if (res_valid & res_ready) begin
            wr_n = 1'b1;
            if (ovf) begin
                state_n = ST_ERR;
                msg_n   = MSG_ERR;
                tmr_clr = 1'b1;
            end else begin
                state_n = ST_NUM;
                msg_n   = MSG_NUM;
                bin_n   = mag[7:0];
                sgn_n   = res_value[9];
                dot_n   = res_dot;
            end
        end else if (prompt_req) begin
            state_n = ST_PROMPT;
            msg_n   = prompt_sel ? MSG_VAL : MSG_OP;
            wr_n    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NUM;
            disp_msg <= MSG_NUM;
            disp_bin <= '0;
            disp_sgn <= 1'b0;
            disp_dot <= '0;
            disp_wr  <= 1'b0;
        end else begin
            state    <= state_n;
            disp_msg <= msg_n;
            disp_bin <= bin_n;
            disp_sgn <= sgn_n;
            disp_dot <= dot_n;
            disp_wr  <= wr_n;
        end
    end

endmodule

// File: tb/tb_disp_msg_sched.sv
// Bench for disp_msg_sched: directed literal scenarios, then randomized traffic vs a timeline model.
module tb_disp_msg_sched;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_value;
    logic [1:0] res_dot;
    logic       err_req;
    logic       prompt_req;
    logic       prompt_sel;
    logic       busy;
    logic [1:0] disp_msg;
    logic       disp_wr;
    logic       disp_sel;
    logic [7:0] disp_bin;
    logic       disp_sgn;
    logic [1:0] disp_dot;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    disp_msg_sched #(.ERR_HOLD(HOLD), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_dot    (res_dot),
        .err_req    (err_req),
        .prompt_req (prompt_req),
        .prompt_sel (prompt_sel),
        .busy       (busy),
        .disp_msg   (disp_msg),
        .disp_wr    (disp_wr),
        .disp_sel   (disp_sel),
        .disp_bin   (disp_bin),
        .disp_sgn   (disp_sgn),
        .disp_dot   (disp_dot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the screen shows, and the edge index at which ERR was (re)entered.
    int m_cyc = 0;
    bit m_in_err = 1'b0;
    int m_err_edge = 0;
    int m_msg = 0, m_bin = 0, m_sgn = 0, m_dot = 0, m_wr = 0;
    int m_v, m_mag;

    always @(posedge clk) begin
        m_cyc++;
        if (rst) begin
            m_in_err = 1'b0;
            m_msg = 0; m_bin = 0; m_sgn = 0; m_dot = 0; m_wr = 0;
        end else begin
            m_wr = 0;
            m_v = int'($signed(res_value));
            m_mag = (m_v < 0) ? -m_v : m_v;
            if (err_req || (!m_in_err && res_valid && m_mag > 255)) begin
                m_in_err = 1'b1;
                m_err_edge = m_cyc;
                m_msg = 3;
                m_wr = 1;
            end else if (m_in_err) begin
                if (m_cyc == m_err_edge + HOLD) begin
                    m_in_err = 1'b0;
                    m_msg = 0; m_bin = 0; m_sgn = 0; m_dot = 0; m_wr = 1;
                end
            end else if (res_valid) begin
                m_msg = 0;
                m_bin = m_mag;
                m_sgn = (m_v < 0) ? 1 : 0;
                m_dot = int'(res_dot);
                m_wr = 1;
            end else if (prompt_req) begin
                m_msg = prompt_sel ? 2 : 1;
                m_wr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msg", int'(disp_msg), m_msg);
            chk("bin", int'(disp_bin), m_bin);
            chk("sgn", int'(disp_sgn), m_sgn);
            chk("dot", int'(disp_dot), m_dot);
            chk("wr", int'(disp_wr), m_wr);
            chk("sel", int'(disp_sel), m_wr);
            chk("busy", int'(busy), int'(m_in_err));
            chk("ready", int'(res_ready), int'(!m_in_err && !err_req));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        res_valid = 1'b0; err_req = 1'b0; prompt_req = 1'b0;
    endtask

    task automatic send(input int v, input int dot);
        res_value = 10'(v); res_dot = 2'(dot); res_valid = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        int v, r;
        rst = 1'b1; res_value = '0; res_dot = '0; prompt_sel = 1'b0;
        idle();
        repeat (3) tick();
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (2) tick();
        chk("rst_msg", int'(disp_msg), 0);
        chk("rst_bin", int'(disp_bin), 0);
        chk("rst_wr", int'(disp_wr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(res_ready), 1);

        send(-37, 1);
        chk("n37_wr", int'(disp_wr), 1);
        chk("n37_bin", int'(disp_bin), 37);
        chk("n37_sgn", int'(disp_sgn), 1);
        chk("n37_dot", int'(disp_dot), 1);
        chk("n37_msg", int'(disp_msg), 0);

        send(300, 0);
        chk("ovf_msg", int'(disp_msg), 3);
        chk("ovf_busy", int'(busy), 1);
        chk("ovf_ready", int'(res_ready), 0);
        repeat (HOLD - 1) tick();
        chk("ovf_hold_msg", int'(disp_msg), 3);
        tick();
        chk("exp_msg", int'(disp_msg), 0);
        chk("exp_bin", int'(disp_bin), 0);
        chk("exp_wr", int'(disp_wr), 1);
        tick();
        chk("exp_wr_once", int'(disp_wr), 0);

        err_req = 1'b1; tick(); idle();
        repeat (4) tick();
        err_req = 1'b1; tick(); idle();
        repeat (HOLD - 1) tick();
        chk("restart_hold", int'(disp_msg), 3);
        tick();
        chk("restart_exp", int'(disp_msg), 0);

        res_value = 10'(5); res_valid = 1'b1; prompt_req = 1'b1; err_req = 1'b1;
        #1;
        chk("tri_ready", int'(res_ready), 0);
        tick(); idle();
        chk("tri_msg", int'(disp_msg), 3);
        repeat (HOLD) tick();
        chk("tri_noprompt", int'(disp_msg), 0);

        send(42, 2);
        prompt_sel = 1'b1; prompt_req = 1'b1; tick(); idle();
        chk("pr_msg", int'(disp_msg), 2);
        chk("pr_bin", int'(disp_bin), 42);
        send(7, 0);
        chk("r7_msg", int'(disp_msg), 0);
        chk("r7_bin", int'(disp_bin), 7);
        send(0, 3);
        chk("zero_sgn", int'(disp_sgn), 0);
        send(-512, 0);
        chk("m512_msg", int'(disp_msg), 3);
        repeat (HOLD) tick();
        send(-255, 0);
        chk("m255_bin", int'(disp_bin), 255);

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: v = -512;
                1: v = 255;
                2: v = -255;
                3: v = 256;
                4: v = 0;
                default: v = int'($urandom_range(0, 1023)) - 512;
            endcase
            res_value  = 10'(v);
            res_dot    = 2'($urandom_range(0, 3));
            res_valid  = ($urandom_range(0, 2) == 0);
            err_req    = ($urandom_range(0, 40) == 0);
            prompt_req = ($urandom_range(0, 5) == 0);
            prompt_sel = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 600) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (HOLD + 2) tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
